// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage and a synchronous instruction RAM.
interface fetch_stage_if #(
  parameter int unsigned PC_W = 32
) ();
  logic [PC_W-1:0] imem_addr;
  logic            imem_en;
  logic [31:0]     imem_rdata;

  modport master (output imem_addr, output imem_en, input imem_rdata);
  modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the one-cycle-latency
// instruction memory and loads the IF/ID register, with stall and redirect.
module fetch_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     INST_NOP = 32'h0000_0000,
  localparam int unsigned    CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       pc_sel,
  input  logic [PC_W-1:0]  rs_target,
  input  logic [PC_W-1:0]  mem_target,
  fetch_stage_if.master    imem,
  output logic [PC_W-1:0]  ifid_pc,
  output logic [31:0]      ifid_inst,
  output logic             ifid_valid,
  output logic             flush_out,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {SRst, SFill, SRun, SHold} stateT;

  stateT           state;
  logic [PC_W-1:0] fa;        // next address to issue
  logic [PC_W-1:0] fPc;       // address whose data is on imem_rdata this cycle
  logic            fValid;
  logic [PC_W-1:0] target;
  logic            redirect;
  logic            advance;

  // Next-PC decision; the reset state ignores pc_sel/stall so the first
  // cycle out of reset always fetches RESET_PC.
  always_comb begin
    redirect       = (state != SRst) && (pc_sel != 2'b00);
    advance        = (state == SRst) || !stall;
    target         = pc_sel[1] ? mem_target : rs_target;
    imem.imem_addr = fa;
    imem.imem_en   = !rst && (redirect || advance);
  end

  // PC, in-flight fetch, IF/ID, flush pulse, counter and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SRst;
      fa          <= RESET_PC;
      fPc         <= '0;
      fValid      <= 1'b0;
      ifid_pc     <= '0;
      ifid_inst   <= INST_NOP;
      ifid_valid  <= 1'b0;
      flush_out   <= 1'b0;
      fetch_count <= '0;
    end else if (redirect) begin
      // the sequential fetch in flight is on the wrong path: drop it
      state      <= SFill;
      fa         <= target;
      fValid     <= 1'b0;
      ifid_pc    <= '0;
      ifid_inst  <= INST_NOP;
      ifid_valid <= 1'b0;
      flush_out  <= 1'b1;
    end else if (advance) begin
      state     <= SRun;
      fa        <= fa + PC_W'(1);
      fPc       <= fa;
      fValid    <= 1'b1;
      flush_out <= 1'b0;
      ifid_pc   <= fPc;
      if (fValid) begin
        ifid_inst   <= imem.imem_rdata;
        ifid_valid  <= 1'b1;
        fetch_count <= fetch_count + CNT_W'(1);
      end else begin
        ifid_inst  <= INST_NOP;
        ifid_valid <= 1'b0;
      end
    end else begin
      // stall: memory output holds because imem_en is low
      state     <= SHold;
      flush_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan scenarios plus random stall,
// redirect and reset traffic against a queue-based transaction model, and a
// second instance at RESET_PC=FFFF_FFFF run long enough to wrap fetch_count.
module tb_fetch_stage;

  logic        clk;
  logic        rst, stall;
  logic [1:0]  pcSel;
  logic [31:0] rsTarget, memTarget;
  logic        rstB;

  logic [31:0] ifidPcA, ifidInstA, ifidPcB, ifidInstB;
  logic        ifidValidA, flushA, ifidValidB, flushB;
  logic [15:0] countA, countB;

  int vecCount = 0;
  int errCount = 0;

  fetch_stage_if #(.PC_W(32)) busA ();
  fetch_stage_if #(.PC_W(32)) busB ();

  fetch_stage #(.PC_W(32), .RESET_PC(32'h0000_0000), .INST_NOP(32'h0000_0000)) dutA (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pcSel),
    .rs_target(rsTarget), .mem_target(memTarget), .imem(busA),
    .ifid_pc(ifidPcA), .ifid_inst(ifidInstA), .ifid_valid(ifidValidA),
    .flush_out(flushA), .fetch_count(countA)
  );

  fetch_stage #(.PC_W(32), .RESET_PC(32'hFFFF_FFFF), .INST_NOP(32'h0000_0000)) dutB (
    .clk(clk), .rst(rstB), .stall(1'b0), .pc_sel(2'b00),
    .rs_target(32'h0), .mem_target(32'h0), .imem(busB),
    .ifid_pc(ifidPcB), .ifid_inst(ifidInstB), .ifid_valid(ifidValidB),
    .flush_out(flushB), .fetch_count(countB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // Synchronous instruction RAMs: one-cycle latency, output holds when disabled.
  always @(posedge clk) if (busA.imem_en) busA.imem_rdata <= memWord(busA.imem_addr);
  always @(posedge clk) if (busB.imem_en) busB.imem_rdata <= memWord(busB.imem_addr);

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: addresses issued but not yet delivered wait in mPend.
  logic        mInRst;
  logic [31:0] mIssue;
  logic [31:0] mPend[$];
  logic        mVal;
  logic [31:0] mPc;
  logic        mPcZero;
  logic        mFlush;
  logic [15:0] mCount;

  function automatic void modelReset();
    mInRst  = 1'b1;
    mIssue  = 32'h0;
    mPend.delete();
    mVal    = 1'b0;
    mPc     = 32'h0;
    mPcZero = 1'b1;
    mFlush  = 1'b0;
    mCount  = 16'h0;
  endfunction

  function automatic void modelEdge(input logic r, input logic s, input logic [1:0] sel,
                                    input logic [31:0] rt, input logic [31:0] mt);
    if (r) begin
      modelReset();
    end else if (!mInRst && sel != 2'b00) begin
      mPend.delete();
      mIssue  = sel[1] ? mt : rt;
      mVal    = 1'b0;
      mPcZero = 1'b1;
      mFlush  = 1'b1;
    end else if (mInRst || !s) begin
      if (mPend.size() != 0) begin
        mPc    = mPend.pop_front();
        mVal   = 1'b1;
        mCount = 16'(mCount + 16'd1);
      end else begin
        mVal = 1'b0;
      end
      mPcZero = mInRst;
      mPend.push_back(mIssue);
      mIssue = mIssue + 32'd1;
      mFlush = 1'b0;
      mInRst = 1'b0;
    end else begin
      mFlush = 1'b0;
    end
  endfunction

  // One cycle on instance A: drive, check at the falling edge, advance model.
  task automatic step(input logic r, input logic s, input logic [1:0] sel,
                      input logic [31:0] rt, input logic [31:0] mt);
    logic expEn;
    rst = r; stall = s; pcSel = sel; rsTarget = rt; memTarget = mt;
    @(negedge clk);
    expEn = !r && (mInRst || sel != 2'b00 || !s);
    checkVal("A_imem_en", 32'(busA.imem_en), 32'(expEn));
    checkVal("A_imem_addr", busA.imem_addr, mIssue);
    checkVal("A_ifid_valid", 32'(ifidValidA), 32'(mVal));
    checkVal("A_ifid_inst", ifidInstA, mVal ? memWord(mPc) : 32'h0);
    if (mVal)         checkVal("A_ifid_pc", ifidPcA, mPc);
    else if (mPcZero) checkVal("A_ifid_pc_clr", ifidPcA, 32'h0);
    checkVal("A_flush_out", 32'(flushA), 32'(mFlush));
    checkVal("A_fetch_count", 32'(countA), 32'(mCount));
    modelEdge(r, s, sel, rt, mt);
    @(posedge clk); #1;
  endtask

  // Instance B never stalls or redirects: cycle c issues FFFF_FFFF+c.
  int   cB = 0;
  logic bDone = 1'b0;
  always @(negedge clk) begin
    if (!rstB && !bDone) begin
      checkVal("B_imem_en", 32'(busB.imem_en), 32'd1);
      checkVal("B_imem_addr", busB.imem_addr, 32'hFFFF_FFFF + 32'(cB));
      if (cB < 2) begin
        checkVal("B_ifid_valid", 32'(ifidValidB), 32'd0);
        checkVal("B_fetch_count", 32'(countB), 32'd0);
      end else begin
        checkVal("B_ifid_valid", 32'(ifidValidB), 32'd1);
        checkVal("B_ifid_pc", ifidPcB, 32'hFFFF_FFFF + 32'(cB - 2));
        checkVal("B_ifid_inst", ifidInstB, memWord(32'hFFFF_FFFF + 32'(cB - 2)));
        checkVal("B_fetch_count", 32'(countB), 32'((cB - 1) % 65536));
      end
      cB = cB + 1;
    end
  end

  initial begin
    rst = 1'b1; rstB = 1'b1; stall = 1'b0; pcSel = 2'b00;
    rsTarget = 32'h0; memTarget = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // held in reset: reset values, inputs ignored
    step(1'b1, 1'b1, 2'b01, 32'h40, 32'h80);
    step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);

    // release and stream, then stall three cycles
    rstB = 1'b0;
    repeat (5) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    repeat (3) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // register redirect to 0x40
    step(1'b0, 1'b0, 2'b01, 32'h40, 32'h0);
    repeat (4) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // mem_target wins over rs_target and over a simultaneous stall
    step(1'b0, 1'b1, 2'b11, 32'h40, 32'h80);
    repeat (4) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // back-to-back redirects
    step(1'b0, 1'b0, 2'b01, 32'h100, 32'h0);
    step(1'b0, 1'b0, 2'b10, 32'h0, 32'h200);
    repeat (4) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // reset during a stall, then during a redirect
    step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    step(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    step(1'b1, 1'b0, 2'b01, 32'h300, 32'h0);
    repeat (4) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // random traffic until instance B has wrapped fetch_count
    for (int i = 0; i < 70000 && cB < 65540; i++) begin
      logic       r, s;
      logic [1:0] sel;
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 3) == 0);
      sel = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(r, s, sel, $urandom, $urandom);
    end
    bDone = 1'b1;
    checkVal("B_run_length", 32'(cB >= 65540), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
